// File: rtl/bno055_poll_ctrl.sv
// bno055_poll_ctrl: sequencer in front of a single-register BNO055 I2C read
// engine. After boot it checks CHIP_ID, then on every poll tick reads the six
// Euler bytes one register per transaction and publishes heading/roll/pitch
// together with a one-cycle valid pulse.
//
// Handshake with the read engine: o_read_start is a one-cycle request that is
// raised together with a stable o_reg_addr; exactly one request is outstanding
// until i_read_done (one cycle, qualified by i_read_data) or the timeout ends
// it. i_read_done arriving in any other state is ignored.
module bno055_poll_ctrl #(
    parameter int unsigned BOOT_CYCLES    = 20000000,
    parameter int unsigned POLL_CYCLES    = 250000,
    parameter int unsigned TIMEOUT_CYCLES = 500000,
    parameter logic [7:0]  CHIP_ID        = 8'hA0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    output logic [7:0]  o_reg_addr,
    output logic        o_read_start,
    input  logic [7:0]  i_read_data,
    input  logic        i_read_done,
    output logic [15:0] o_heading,
    output logic [15:0] o_roll,
    output logic [15:0] o_pitch,
    output logic        o_valid,
    output logic        o_chip_ok,
    output logic [7:0]  o_err_cnt
);

    localparam logic [31:0] BOOT_LAST    = 32'(BOOT_CYCLES - 1);
    localparam logic [31:0] POLL_LAST    = 32'(POLL_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  EULER_BASE   = 8'h1A;

    typedef enum logic [2:0] {
        S_BOOT,
        S_ID_REQ,
        S_ID_WAIT,
        S_ID_HOLD,
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_PUBLISH
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] boot_cnt_q, boot_cnt_d;
    logic [31:0] poll_cnt_q, poll_cnt_d;
    logic [31:0] to_cnt_q, to_cnt_d;
    logic        tick_q, tick_d;
    logic [2:0]  idx_q, idx_d;
    // Bytes 0x1A..0x1E; the last byte (0x1F) goes straight into o_pitch.
    logic [4:0][7:0] shadow_q, shadow_d;
    logic [7:0]  reg_addr_q, reg_addr_d;
    logic        read_start_q, read_start_d;
    logic [15:0] heading_q, heading_d;
    logic [15:0] roll_q, roll_d;
    logic [15:0] pitch_q, pitch_d;
    logic        valid_q, valid_d;
    logic        chip_ok_q, chip_ok_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        poll_wrap;
    logic        tick_clr;
    logic        err_inc;

    // Free-running poll period counter; its wrap raises the poll tick.
    always_comb begin
        poll_wrap  = (poll_cnt_q == POLL_LAST);
        poll_cnt_d = poll_wrap ? 32'd0 : poll_cnt_q + 32'd1;
    end

    // Next-state and output logic of the polling FSM.
    always_comb begin
        state_d      = state_q;
        boot_cnt_d   = boot_cnt_q;
        to_cnt_d     = to_cnt_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        reg_addr_d   = reg_addr_q;
        read_start_d = 1'b0;
        heading_d    = heading_q;
        roll_d       = roll_q;
        pitch_d      = pitch_q;
        valid_d      = 1'b0;
        chip_ok_d    = chip_ok_q;
        tick_clr     = 1'b0;
        err_inc      = 1'b0;

        case (state_q)
            S_BOOT: begin
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = S_ID_REQ;
                end else begin
                    boot_cnt_d = boot_cnt_q + 32'd1;
                end
            end
            S_ID_REQ: begin
                reg_addr_d   = 8'h00;
                read_start_d = 1'b1;
                to_cnt_d     = 32'd0;
                state_d      = S_ID_WAIT;
            end
            S_ID_WAIT: begin
                // A done in the timeout cycle still counts as a completion.
                if (i_read_done) begin
                    chip_ok_d = (i_read_data == CHIP_ID);
                    if (i_read_data == CHIP_ID) begin
                        state_d = S_IDLE;
                    end else begin
                        err_inc = 1'b1;
                        state_d = S_ID_HOLD;
                    end
                end else if (to_cnt_q == TIMEOUT_LAST) begin
                    chip_ok_d = 1'b0;
                    err_inc   = 1'b1;
                    state_d   = S_ID_HOLD;
                end else begin
                    to_cnt_d = to_cnt_q + 32'd1;
                end
            end
            S_ID_HOLD: begin
                // Retry the identity check once per poll period.
                if (tick_q) begin
                    tick_clr = 1'b1;
                    state_d  = S_ID_REQ;
                end
            end
            S_IDLE: begin
                if (tick_q && i_enable) begin
                    idx_d    = 3'd0;
                    tick_clr = 1'b1;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                reg_addr_d   = EULER_BASE + {5'd0, idx_q};
                read_start_d = 1'b1;
                to_cnt_d     = 32'd0;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                if (i_read_done) begin
                    if (idx_q == 3'd5) begin
                        // Load all three words together with the valid pulse.
                        heading_d = {shadow_q[1], shadow_q[0]};
                        roll_d    = {shadow_q[3], shadow_q[2]};
                        pitch_d   = {i_read_data, shadow_q[4]};
                        valid_d   = 1'b1;
                        state_d   = S_PUBLISH;
                    end else begin
                        shadow_d[idx_q] = i_read_data;
                        idx_d           = idx_q + 3'd1;
                        tick_clr        = 1'b1;
                        state_d         = S_REQ;
                    end
                end else if (to_cnt_q == TIMEOUT_LAST) begin
                    // Partial frame is dropped; published words stay as they were.
                    err_inc = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 32'd1;
                end
            end
            S_PUBLISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase

        // A wrap in the same cycle as a clear leaves the tick pending.
        tick_d    = (tick_q & ~tick_clr) | poll_wrap;
        err_cnt_d = (err_inc && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_BOOT;
            boot_cnt_q   <= 32'd0;
            poll_cnt_q   <= 32'd0;
            to_cnt_q     <= 32'd0;
            tick_q       <= 1'b0;
            idx_q        <= 3'd0;
            shadow_q     <= '0;
            reg_addr_q   <= 8'h00;
            read_start_q <= 1'b0;
            heading_q    <= 16'h0000;
            roll_q       <= 16'h0000;
            pitch_q      <= 16'h0000;
            valid_q      <= 1'b0;
            chip_ok_q    <= 1'b0;
            err_cnt_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            boot_cnt_q   <= boot_cnt_d;
            poll_cnt_q   <= poll_cnt_d;
            to_cnt_q     <= to_cnt_d;
            tick_q       <= tick_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            reg_addr_q   <= reg_addr_d;
            read_start_q <= read_start_d;
            heading_q    <= heading_d;
            roll_q       <= roll_d;
            pitch_q      <= pitch_d;
            valid_q      <= valid_d;
            chip_ok_q    <= chip_ok_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign o_reg_addr   = reg_addr_q;
    assign o_read_start = read_start_q;
    assign o_heading    = heading_q;
    assign o_roll       = roll_q;
    assign o_pitch      = pitch_q;
    assign o_valid      = valid_q;
    assign o_chip_ok    = chip_ok_q;
    assign o_err_cnt    = err_cnt_q;

endmodule

// File: doc/bno055_poll_ctrl.md
Name: bno055_poll_ctrl

Overview:
- Upstream sequencer for the single-register BNO055 I2C read engine.
- After sensor boot, verifies CHIP_ID (reg 0x00 = 0xA0), then periodically reads the six Euler bytes (0x1A..0x1F) one register per transaction.
- Assembles little-endian 16-bit heading/roll/pitch and publishes them atomically to the attitude-display logic.
- Sensor mode configuration is out of scope.

Parameters:
- BOOT_CYCLES, 20000000: idle cycles after reset before the first transaction (800 ms at 25 MHz).
- POLL_CYCLES, 250000: poll period in cycles (100 Hz at 25 MHz); must be >= 2.
- TIMEOUT_CYCLES, 500000: maximum cycles from read request to read-engine done before abort.
- CHIP_ID, 8'hA0: expected CHIP_ID value.

Ports:
- i_clk, in, 1: clock.
- i_rst, in, 1: reset, asynchronous, active-high.
- i_enable, in, 1: allows new Euler frames to start.
- o_reg_addr, out, 8: register address driven to the read engine.
- o_read_start, out, 1: one-cycle request pulse to the read engine.
- i_read_data, in, 8: byte returned by the read engine.
- i_read_done, in, 1: one-cycle completion pulse from the read engine.
- o_heading, out, 16: {reg 0x1B, reg 0x1A}.
- o_roll, out, 16: {reg 0x1D, reg 0x1C}.
- o_pitch, out, 16: {reg 0x1F, reg 0x1E}.
- o_valid, out, 1: one-cycle pulse when the three outputs update.
- o_chip_ok, out, 1: last CHIP_ID read matched.
- o_err_cnt, out, 8: saturating count of timeouts and CHIP_ID mismatches.

Behaviour:
- Reset: all outputs 0; state S_BOOT; boot/poll/timeout counters, byte index and tick_pending cleared.
- Reset is honoured mid-transaction; an abandoned engine transaction is not tracked.
- Poll counter: free-running from reset, wraps at POLL_CYCLES-1. Wrap sets tick_pending (single level, not queued); entering S_REQ clears it.
- S_BOOT: count BOOT_CYCLES, then go to S_ID_REQ.
- S_ID_REQ:
  - o_reg_addr <= 0x00; pulse o_read_start; clear timeout counter; go to S_ID_WAIT.
- S_ID_WAIT:
  - On i_read_done: o_chip_ok <= (i_read_data == CHIP_ID). On match go to S_IDLE; on mismatch increment o_err_cnt and go to S_ID_HOLD.
  - On timeout counter reaching TIMEOUT_CYCLES-1 with no done: o_chip_ok <= 0; increment o_err_cnt; go to S_ID_HOLD.
- S_ID_HOLD: on tick_pending, clear it and go to S_ID_REQ (retry once per poll period).
- S_IDLE: if tick_pending && i_enable, go to S_REQ with idx <= 0.
- S_REQ:
  - o_reg_addr <= 0x1A + idx; pulse o_read_start; clear timeout counter; go to S_WAIT.
  - o_reg_addr holds stable until the next S_REQ or S_ID_REQ.
- S_WAIT:
  - On i_read_done: shadow[idx] <= i_read_data. If idx == 5 go to S_PUBLISH; otherwise idx++ and go to S_REQ.
  - On timeout: increment o_err_cnt; discard the partial frame (outputs unchanged); go to S_IDLE.
- S_PUBLISH:
  - Load o_heading, o_roll, o_pitch from the shadow bytes in the same cycle.
  - o_valid = 1 for exactly one cycle; go to S_IDLE.
- i_read_done outside S_WAIT / S_ID_WAIT is ignored.
- Done and timeout in the same cycle: done wins.
- i_enable is sampled only in S_IDLE; a frame in flight always completes or times out.
- o_err_cnt saturates at 255.
- Latency: S_REQ pulse to next S_REQ pulse = engine latency + 2 cycles; last done to o_valid = 1 cycle.
- Exactly one request is outstanding at any time.

Test Plan:
- Params BOOT_CYCLES=10, POLL_CYCLES=100, TIMEOUT_CYCLES=50; engine model answers 5 cycles after o_read_start; CHIP_ID returns 0xA0 -> first o_read_start at cycle 10 with addr 0x00, o_chip_ok=1, o_err_cnt=0.
- Euler bytes 0x34,0x12,0x78,0x56,0xBC,0x9A -> six requests at addresses 0x1A..0x1F in order; o_heading=0x1234, o_roll=0x5678, o_pitch=0x9ABC; single o_valid pulse.
- CHIP_ID returns 0x00 -> o_chip_ok=0, o_err_cnt=1, no Euler request; retry on next tick; then 0xA0 -> o_chip_ok=1 and Euler polling starts.
- Engine withholds done on the 3rd Euler byte -> abort 50 cycles after its request; o_err_cnt increments; previous outputs unchanged; no o_valid; next frame restarts at 0x1A.
- i_enable=0 for 3 poll periods -> no Euler requests; raise i_enable -> exactly one frame starts at the next tick (tick not queued).
- Assert i_rst mid-frame (during S_WAIT) -> all outputs 0 immediately; S_BOOT restarts; stray i_read_done after reset is ignored.
